calc_sequencer: RTL and testbench

Clocked controller between the keypad encoder and the shared arithmetic unit and display. It assembles two 2-digit decimal operands and an operator from key events. It issues one start/done transaction to the multi-cycle arithmetic unit, converts the binary result to BCD sequentially, and drives the four 7-seg digit nibbles. It replaces event-edge sequencing with a single-clock synchronous FSM.

---
 rtl/calc_pkg.sv | 54 +++++
 rtl/calc_sequencer_bcd_dabble_seq.sv | 50 +++++
 rtl/calc_sequencer.sv | 231 +++++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: key codes, operator
// encodings, one-hot state encoding and small conversion helpers.
package calc_pkg;

    localparam logic [7:0] KEY_DIG_MAX = 8'h09;
    localparam logic [7:0] KEY_ADD     = 8'hF0;
    localparam logic [7:0] KEY_SUB     = 8'hF1;
    localparam logic [7:0] KEY_MUL     = 8'hF2;
    localparam logic [7:0] KEY_DIV     = 8'hF3;
    localparam logic [7:0] KEY_EQ      = 8'hFE;
    localparam logic [7:0] KEY_CLR     = 8'hFF;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int         CALC_TIMEOUT_DEF = 64;
    localparam logic [3:0] BLANK_NIB_DEF    = 4'hF;
    localparam logic [3:0] ERR_NIB          = 4'hE;

    typedef enum logic [10:0] {
        S_IDLE = 11'b000_0000_0001,
        S_A1   = 11'b000_0000_0010,
        S_A0   = 11'b000_0000_0100,
        S_OPW  = 11'b000_0000_1000,
        S_B1   = 11'b000_0001_0000,
        S_B0   = 11'b000_0010_0000,
        S_EXEC = 11'b000_0100_0000,
        S_WAIT = 11'b000_1000_0000,
        S_CONV = 11'b001_0000_0000,
        S_SHOW = 11'b010_0000_0000,
        S_ERR  = 11'b100_0000_0000
    } state_t;

    // Two BCD digits to binary: 10*t + o = 8*t + 2*t + o
    function automatic logic [6:0] dec2bin(input logic [3:0] t,
                                           input logic [3:0] o);
        return {t, 3'b000} + {2'b00, t, 1'b0} + {3'b000, o};
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before shifting
    function automatic logic [15:0] dabble_adj(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_sequencer_bcd_dabble_seq.sv
// bcd_dabble_seq: 14-bit binary to 4-digit BCD, one shift per clock.
// Ports: clk, rst (sync active-low), start, bin[13:0] -> done pulse, bcd[15:0].
module bcd_dabble_seq
    import calc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        done,
    output logic [15:0] bcd
);

    logic [13:0] r_sh;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_done;
    logic [15:0] w_adj;

    assign w_adj = dabble_adj(r_bcd);

    // The first shift happens on the start edge (BCD is zero, so no
    // correction is needed); 13 more follow, giving done 14 cycles after start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh   <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_bcd <= {15'd0, bin[13]};
                r_sh  <= {bin[12:0], 1'b0};
                r_cnt <= 4'd13;
            end else if (r_cnt != 4'd0) begin
                r_bcd <= {w_adj[14:0], r_sh[13]};
                r_sh  <= {r_sh[12:0], 1'b0};
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done = r_done;
    assign bcd  = r_bcd;

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: key-driven operand/operator entry, one arithmetic-unit
// transaction, sequential BCD conversion and 4-nibble display drive.
// Ports: clk, rst (sync active-low), key_valid/key_code in; calc_start,
// calc_a, calc_b, calc_op out; calc_done/calc_result/calc_err in; busy,
// digit4..digit1 out. Optional macro CALC_CHAIN_EN: operator key in SHOW
// reuses a result <= 99 as operand A.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int         CALC_TIMEOUT = CALC_TIMEOUT_DEF,
    parameter logic [3:0] BLANK_NIB    = BLANK_NIB_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic        calc_start,
    output logic [6:0]  calc_a,
    output logic [6:0]  calc_b,
    output logic [1:0]  calc_op,
    input  logic        calc_done,
    input  logic [13:0] calc_result,
    input  logic        calc_err,
    output logic        busy,
    output logic [3:0]  digit4,
    output logic [3:0]  digit3,
    output logic [3:0]  digit2,
    output logic [3:0]  digit1
);

    localparam int CW = $clog2(CALC_TIMEOUT + 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_a_t, r_a_o, r_b_t, r_b_o;
    logic [1:0]    r_op;
    logic [6:0]    r_calc_a, r_calc_b;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_d4, r_d3, r_d2, r_d1;
`ifdef CALC_CHAIN_EN
    logic [3:0]    r_res_t, r_res_o;
    logic          r_small;
`endif

    logic          w_dig, w_op, w_eq, w_clr, w_tmo;
    logic [3:0]    w_d;
    logic          w_bcd_start, w_bcd_done;
    logic [15:0]   w_bcd;

    assign w_dig = key_valid && (key_code <= KEY_DIG_MAX);
    assign w_op  = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
    assign w_eq  = key_valid && (key_code == KEY_EQ);
    assign w_clr = key_valid && (key_code == KEY_CLR);
    assign w_d   = key_code[3:0];

    // r_cnt holds cycles elapsed since calc_start (1 in the first WAIT cycle)
    assign w_tmo = (r_cnt == CW'(CALC_TIMEOUT - 1));

    assign w_bcd_start = (r_state == S_WAIT) && calc_done && !calc_err;

    bcd_dabble_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_bcd_start),
        .bin   (calc_result),
        .done  (w_bcd_done),
        .bcd   (w_bcd)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_clr) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: if (w_dig) w_next = S_A1;
                S_A1:   if (w_dig) w_next = S_A0;
                S_A0:   if (w_op)  w_next = S_OPW;
                S_OPW:  if (w_dig) w_next = S_B1;
                S_B1:   if (w_dig) w_next = S_B0;
                S_B0:   if (w_eq)  w_next = S_EXEC;
                S_EXEC: w_next = S_WAIT;
                S_WAIT: begin
                    if (calc_done) begin
                        w_next = calc_err ? S_ERR : S_CONV;
                    end else if (w_tmo) begin
                        w_next = S_ERR;
                    end
                end
                S_CONV: if (w_bcd_done) w_next = S_SHOW;
                S_SHOW: begin
                    if (w_dig) begin
                        w_next = S_A1;
                    end
`ifdef CALC_CHAIN_EN
                    else if (w_op && r_small) begin
                        w_next = S_OPW;
                    end
`endif
                end
                S_ERR:  w_next = S_ERR;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || w_clr) begin
            r_a_t    <= 4'd0;
            r_a_o    <= 4'd0;
            r_b_t    <= 4'd0;
            r_b_o    <= 4'd0;
            r_op     <= OP_ADD;
            r_calc_a <= 7'd0;
            r_calc_b <= 7'd0;
            r_cnt    <= '0;
            r_d4     <= BLANK_NIB;
            r_d3     <= BLANK_NIB;
            r_d2     <= BLANK_NIB;
            r_d1     <= 4'd0;
`ifdef CALC_CHAIN_EN
            r_res_t  <= 4'd0;
            r_res_o  <= 4'd0;
            r_small  <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                S_IDLE, S_SHOW: begin
                    if (w_dig) begin
                        r_a_t <= w_d;
                        r_d4  <= BLANK_NIB;
                        r_d3  <= BLANK_NIB;
                        r_d2  <= BLANK_NIB;
                        r_d1  <= w_d;
                    end
`ifdef CALC_CHAIN_EN
                    else if (r_state == S_SHOW && w_op && r_small) begin
                        r_a_t <= r_res_t;
                        r_a_o <= r_res_o;
                        r_op  <= key_code[1:0];
                        r_d4  <= BLANK_NIB;
                        r_d3  <= BLANK_NIB;
                        r_d2  <= BLANK_NIB;
                        r_d1  <= BLANK_NIB;
                    end
`endif
                end
                S_A1: begin
                    if (w_dig) begin
                        r_a_o <= w_d;
                        r_d2  <= r_a_t;
                        r_d1  <= w_d;
                    end
                end
                S_A0: begin
                    if (w_op) begin
                        r_op <= key_code[1:0];
                        r_d4 <= BLANK_NIB;
                        r_d3 <= BLANK_NIB;
                        r_d2 <= BLANK_NIB;
                        r_d1 <= BLANK_NIB;
                    end
                end
                S_OPW: begin
                    if (w_dig) begin
                        r_b_t <= w_d;
                        r_d1  <= w_d;
                    end
                end
                S_B1: begin
                    if (w_dig) begin
                        r_b_o <= w_d;
                        r_d2  <= r_b_t;
                        r_d1  <= w_d;
                    end
                end
                S_B0: begin
                    if (w_eq) begin
                        r_calc_a <= dec2bin(r_a_t, r_a_o);
                        r_calc_b <= dec2bin(r_b_t, r_b_o);
                    end
                end
                S_EXEC: r_cnt <= CW'(1);
                S_WAIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if ((calc_done && calc_err) || (!calc_done && w_tmo)) begin
                        r_d4 <= ERR_NIB;
                        r_d3 <= BLANK_NIB;
                        r_d2 <= BLANK_NIB;
                        r_d1 <= BLANK_NIB;
                    end
                end
                S_CONV: begin
                    if (w_bcd_done) begin
                        // Leading-zero blanking; the ones digit always shows
                        r_d4 <= (w_bcd[15:12] == 4'd0) ? BLANK_NIB : w_bcd[15:12];
                        r_d3 <= (w_bcd[15:8] == 8'd0) ? BLANK_NIB : w_bcd[11:8];
                        r_d2 <= (w_bcd[15:4] == 12'd0) ? BLANK_NIB : w_bcd[7:4];
                        r_d1 <= w_bcd[3:0];
`ifdef CALC_CHAIN_EN
                        r_res_t <= w_bcd[7:4];
                        r_res_o <= w_bcd[3:0];
                        r_small <= (w_bcd[15:8] == 8'd0);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign calc_start = (r_state == S_EXEC);
    assign busy       = (r_state == S_EXEC) || (r_state == S_WAIT) ||
                        (r_state == S_CONV);
    assign calc_a     = r_calc_a;
    assign calc_b     = r_calc_b;
    assign calc_op    = r_op;
    assign digit4     = r_d4;
    assign digit3     = r_d3;
    assign digit2     = r_d2;
    assign digit1     = r_d1;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with an inline arithmetic-unit model
// and a scoreboard of expected operands and display values.
module tb_calc_sequencer;
    import calc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic        calc_done = 1'b0;
    logic [13:0] calc_result = 14'd0;
    logic        calc_err = 1'b0;
    logic        calc_start, busy;
    logic [6:0]  calc_a, calc_b;
    logic [1:0]  calc_op;
    logic [3:0]  digit4, digit3, digit2, digit1;
    logic [15:0] disp;

    assign disp = {digit4, digit3, digit2, digit1};

    calc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .calc_start  (calc_start),
        .calc_a      (calc_a),
        .calc_b      (calc_b),
        .calc_op     (calc_op),
        .calc_done   (calc_done),
        .calc_result (calc_result),
        .calc_err    (calc_err),
        .busy        (busy),
        .digit4      (digit4),
        .digit3      (digit3),
        .digit2      (digit2),
        .digit1      (digit1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_vec = 0;
    int n_err = 0;
    int t_start = 0;
    int t_end = 0;

    typedef struct packed {
        logic [6:0] a;
        logic [6:0] b;
        logic [1:0] op;
    } calc_t;

    calc_t       q_calc[$];
    logic [15:0] q_disp[$];

    function automatic int model(input int a, input int b, input logic [1:0] op);
        case (op)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a * b;
            default: return (b == 0) ? 0 : a / b;
        endcase
    endfunction

    function automatic logic [15:0] to_disp(input int r);
        logic [15:0] v;
        v[3:0]   = 4'(r % 10);
        v[7:4]   = (r < 10)   ? 4'hF : 4'((r / 10) % 10);
        v[11:8]  = (r < 100)  ? 4'hF : 4'((r / 100) % 10);
        v[15:12] = (r < 1000) ? 4'hF : 4'((r / 1000) % 10);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [7:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic equal(input int a, input int b, input logic [1:0] op,
                         input logic [15:0] d);
        calc_t e;
        e.a  = 7'(a);
        e.b  = 7'(b);
        e.op = op;
        q_calc.push_back(e);
        q_disp.push_back(d);
        press(KEY_EQ);
    endtask

    task automatic expect_start(input string tag);
        calc_t e;
        for (int i = 0; i < 10; i++) begin
            if (calc_start) break;
            @(negedge clk);
        end
        t_start = cyc;
        e = q_calc.pop_front();
        chk({tag, "_start"}, calc_start, 1);
        chk({tag, "_a"}, calc_a, e.a);
        chk({tag, "_b"}, calc_b, e.b);
        chk({tag, "_op"}, calc_op, e.op);
        chk({tag, "_busy"}, busy, 1);
    endtask

    task automatic respond(input int lat, input int res, input logic err);
        @(negedge clk);
        chk("start_pulse", calc_start, 0);
        repeat (lat - 1) @(negedge clk);
        calc_done   = 1'b1;
        calc_result = 14'(res);
        calc_err    = err;
        @(negedge clk);
        calc_done   = 1'b0;
        calc_result = 14'd0;
        calc_err    = 1'b0;
    endtask

    task automatic expect_disp(input string tag);
        logic [15:0] e;
        for (int i = 0; i < 120; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        chk({tag, "_idle"}, busy, 0);
        t_end = cyc;
        e = q_disp.pop_front();
        chk(tag, disp, e);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_disp", disp, 16'hFFF0);
        chk("rst_start", calc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_a", calc_a, 0);
        rst = 1'b1;

        press(8'h04);
        chk("t1_d4", disp, 16'hFFF4);
        press(8'h02);
        chk("t1_d42", disp, 16'hFF42);
        press(8'h05);
        chk("t1_a0_dig", disp, 16'hFF42);
        press(KEY_ADD);
        chk("t1_op", disp, 16'hFFFF);
        press(8'h0A);
        press(8'hF5);
        chk("t1_undef", disp, 16'hFFFF);
        press(8'h01);
        press(8'h07);
        chk("t1_b17", disp, 16'hFF17);
        equal(42, 17, OP_ADD, to_disp(model(42, 17, OP_ADD)));
        expect_start("t1");
        respond(5, model(42, 17, OP_ADD), 1'b0);
        expect_disp("t1_disp");

`ifdef CALC_CHAIN_EN
        press(KEY_SUB);
        chk("ch_op", disp, 16'hFFFF);
        press(8'h02);
        press(8'h00);
        equal(59, 20, OP_SUB, to_disp(model(59, 20, OP_SUB)));
        expect_start("ch");
        respond(4, model(59, 20, OP_SUB), 1'b0);
        expect_disp("ch_disp");
        press(8'h06);
        press(8'h00);
        press(KEY_ADD);
        press(8'h06);
        press(8'h00);
        equal(60, 60, OP_ADD, to_disp(model(60, 60, OP_ADD)));
        expect_start("ch120");
        respond(3, model(60, 60, OP_ADD), 1'b0);
        expect_disp("ch120_disp");
        press(KEY_MUL);
        chk("ch120_op_ign", disp, 16'hF120);
        press(8'h01);
        press(8'h02);
        press(KEY_EQ);
        chk("ch120_noexec", busy, 0);
        chk("ch120_a12", disp, 16'hFF12);
`else
        press(KEY_SUB);
        chk("show_op_ign", disp, 16'hFF59);
        press(8'h02);
        chk("show_dig", disp, 16'hFFF2);
        press(8'h00);
        press(KEY_EQ);
        chk("show_noexec", busy, 0);
        chk("show_a20", disp, 16'hFF20);
`endif
        press(KEY_CLR);

        press(8'h09);
        press(8'h09);
        press(KEY_MUL);
        press(8'h09);
        press(8'h09);
        equal(99, 99, OP_MUL, to_disp(model(99, 99, OP_MUL)));
        expect_start("t2");
        respond(5, model(99, 99, OP_MUL), 1'b0);
        expect_disp("t2_disp");
        chk("t2_busy_span", t_end - t_start, 1 + 5 + 14);

        press(8'h01);
        press(8'h02);
        press(KEY_SUB);
        press(8'h03);
        press(8'h04);
        chk("b0_op", calc_op, OP_SUB);
        chk("b0_disp", disp, 16'hFF34);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst2_disp", disp, 16'hFFF0);
        chk("rst2_a", calc_a, 0);
        chk("rst2_b", calc_b, 0);
        chk("rst2_op", calc_op, 0);
        chk("rst2_busy", busy, 0);

        press(8'h00);
        press(8'h05);
        chk("t3_a", disp, 16'hFF05);
        press(KEY_DIV);
        press(8'h00);
        press(8'h00);
        equal(5, 0, OP_DIV, 16'hEFFF);
        expect_start("t3");
        respond(3, 0, 1'b1);
        expect_disp("t3_err");
        press(8'h03);
        chk("t3_err_dig", disp, 16'hEFFF);
        press(KEY_CLR);
        chk("t3_clr", disp, 16'hFFF0);
        chk("t3_clr_busy", busy, 0);

        press(8'h01);
        press(8'h02);
        press(KEY_MUL);
        press(8'h03);
        press(8'h04);
        equal(12, 34, OP_MUL, 16'hEFFF);
        expect_start("t4");
        expect_disp("t4_tmo");
        chk("t4_tmo_cycles", t_end - t_start, 64);
        press(KEY_CLR);

        press(8'h02);
        press(8'h01);
        press(KEY_ADD);
        press(8'h01);
        press(8'h01);
        equal(21, 11, OP_ADD, 16'h0000);
        void'(q_disp.pop_back());
        expect_start("t5");
        repeat (3) @(negedge clk);
        press(KEY_CLR);
        chk("t5_clr", disp, 16'hFFF0);
        chk("t5_clr_busy", busy, 0);
        respond(2, 32, 1'b0);
        repeat (20) @(negedge clk);
        chk("t5_late", disp, 16'hFFF0);
        chk("t5_late_busy", busy, 0);
        press(8'h07);
        chk("t5_idle_dig", disp, 16'hFFF7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
